// File: rtl/jt10_adpcma_sched_if.sv
// Sample ROM request/acknowledge port shared by the ADPCM-A sequencer.
interface jt10_adpcma_sched_if #(
  parameter int unsigned ADDRW = 24
);
  logic [ADDRW-1:0] rom_addr;
  logic             rom_cs;
  logic [7:0]       rom_data;
  logic             rom_ok;

  modport master (output rom_addr, output rom_cs, input rom_data, input rom_ok);
  modport slave  (input rom_addr, input rom_cs, output rom_data, output rom_ok);
endinterface

// File: rtl/jt10_adpcma_sched.sv
// Six-channel ADPCM-A sequencer: prefetches sample bytes over one ROM port and
// presents one channel nibble per cen slot. Define JT10_ADPCMA_EOS_EN for eos/eos_clr.
module jt10_adpcma_sched #(
  parameter int unsigned ADDRW = 24
) (
  input  logic        rst_n,
  input  logic        clk,
  input  logic        cen,
  input  logic        wr_en,
  input  logic [2:0]  wr_ch,
  input  logic        wr_sel,
  input  logic [15:0] wr_data,
  input  logic [5:0]  keyon,
  input  logic [5:0]  keyoff,
  output logic [2:0]  slot,
  output logic [3:0]  dec_data,
  output logic        dec_chon,
  output logic [5:0]  playing,
  output logic [5:0]  underrun,
`ifdef JT10_ADPCMA_EOS_EN
  input  logic [5:0]  eos_clr,
  output logic [5:0]  eos,
`endif
  jt10_adpcma_sched_if.master rom
);
  localparam int unsigned NCH = 6;

  typedef enum logic {F_IDLE, F_REQ} fstate_e;

  logic [15:0]      start_q [NCH], start_d [NCH];
  logic [15:0]      end_q   [NCH], end_d   [NCH];
  logic [ADDRW-1:0] addr_q  [NCH], addr_d  [NCH];
  logic [7:0]       buf_q   [NCH], buf_d   [NCH];
  logic [5:0]       bvalid_q, bvalid_d, nib_q, nib_d, on_q, on_d;
  logic [5:0]       rst_pend_q, rst_pend_d, gen_q, gen_d;
  logic [5:0]       underrun_q, underrun_d, playing_q, playing_d;
  logic [2:0]       sc_q, sc_d, slot_q, slot_d;
  logic [3:0]       dec_data_q, dec_data_d;
  logic             dec_chon_q, dec_chon_d;

  fstate_e          fstate_q, fstate_d;
  logic             rom_cs_q, rom_cs_d;
  logic [ADDRW-1:0] rom_addr_q, rom_addr_d;
  logic [2:0]       req_ch_q, req_ch_d, last_q, last_d;
  logic             req_gen_q, req_gen_d;
  logic [5:0]       elig_c;
  logic [2:0]       pick_c, idx_c;
  logic             found_c, fill_c;
`ifdef JT10_ADPCMA_EOS_EN
  logic [5:0]       eos_q, eos_d;
`endif

  assign elig_c = (on_q | rst_pend_q) & ~bvalid_q;

  // Fetch engine: round-robin grant starting after the last channel served.
  always_comb begin
    fstate_d   = fstate_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    req_ch_d   = req_ch_q;
    req_gen_d  = req_gen_q;
    last_d     = last_q;
    fill_c     = 1'b0;
    pick_c     = last_q;
    idx_c      = 3'd0;
    found_c    = 1'b0;
    for (int i = NCH; i >= 1; i--) begin
      idx_c = 3'((int'(last_q) + i) % NCH);
      if (elig_c[idx_c]) begin
        pick_c  = idx_c;
        found_c = 1'b1;
      end
    end
    case (fstate_q)
      F_IDLE: if (found_c) begin
        fstate_d   = F_REQ;
        rom_cs_d   = 1'b1;
        rom_addr_d = addr_q[pick_c];
        req_ch_d   = pick_c;
        req_gen_d  = gen_q[pick_c];
        last_d     = pick_c;
      end
      F_REQ: if (rom.rom_ok) begin
        fstate_d = F_IDLE;
        rom_cs_d = 1'b0;
        // a key event since the grant makes the returning byte stale
        fill_c   = (gen_q[req_ch_q] == req_gen_q) && elig_c[req_ch_q];
      end
      default: fstate_d = F_IDLE;
    endcase
  end

  // Channel state: register writes, buffer fill, slot service, key events.
  always_comb begin
    start_d    = start_q;
    end_d      = end_q;
    addr_d     = addr_q;
    buf_d      = buf_q;
    bvalid_d   = bvalid_q;
    nib_d      = nib_q;
    on_d       = on_q;
    rst_pend_d = rst_pend_q;
    gen_d      = gen_q;
    underrun_d = underrun_q;
    sc_d       = sc_q;
    slot_d     = slot_q;
    dec_data_d = dec_data_q;
    dec_chon_d = dec_chon_q;
`ifdef JT10_ADPCMA_EOS_EN
    eos_d      = eos_q & ~eos_clr;
`endif
    if (wr_en && (wr_ch < 3'd6)) begin
      if (wr_sel) end_d[wr_ch]   = wr_data;
      else        start_d[wr_ch] = wr_data;
    end
    if (fill_c) begin
      buf_d[req_ch_q]    = rom.rom_data;
      bvalid_d[req_ch_q] = 1'b1;
    end
    if (cen) begin
      slot_d     = sc_q;
      sc_d       = (sc_q == 3'd5) ? 3'd0 : sc_q + 3'd1;
      dec_chon_d = 1'b0;
      dec_data_d = 4'd0;
      if (rst_pend_q[sc_q]) begin
        rst_pend_d[sc_q] = 1'b0;
        on_d[sc_q]       = 1'b1;
      end else if (on_q[sc_q]) begin
        dec_chon_d = 1'b1;
        if (bvalid_q[sc_q]) begin
          dec_data_d  = nib_q[sc_q] ? buf_q[sc_q][3:0] : buf_q[sc_q][7:4];
          nib_d[sc_q] = ~nib_q[sc_q];
          if (nib_q[sc_q]) begin
            bvalid_d[sc_q] = 1'b0;
            if (addr_q[sc_q] == ADDRW'({end_q[sc_q], 8'hFF})) begin
              on_d[sc_q] = 1'b0;
`ifdef JT10_ADPCMA_EOS_EN
              eos_d[sc_q] = 1'b1;
`endif
            end else begin
              addr_d[sc_q] = addr_q[sc_q] + ADDRW'(1);
            end
          end
        end else begin
          underrun_d[sc_q] = 1'b1;
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (keyoff[c]) begin
        on_d[c]       = 1'b0;
        rst_pend_d[c] = 1'b0;
        bvalid_d[c]   = 1'b0;
      end else if (keyon[c]) begin
        addr_d[c]     = ADDRW'({start_q[c], 8'h00});
        nib_d[c]      = 1'b0;
        bvalid_d[c]   = 1'b0;
        rst_pend_d[c] = 1'b1;
        on_d[c]       = 1'b0;
        underrun_d[c] = 1'b0;
        gen_d[c]      = ~gen_q[c];
`ifdef JT10_ADPCMA_EOS_EN
        eos_d[c]      = 1'b0;
`endif
      end
    end
    playing_d = on_d | rst_pend_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        start_q[c] <= '0;
        end_q[c]   <= '0;
        addr_q[c]  <= '0;
        buf_q[c]   <= '0;
      end
      bvalid_q   <= '0;
      nib_q      <= '0;
      on_q       <= '0;
      rst_pend_q <= '0;
      gen_q      <= '0;
      underrun_q <= '0;
      playing_q  <= '0;
      sc_q       <= '0;
      slot_q     <= '0;
      dec_data_q <= '0;
      dec_chon_q <= 1'b0;
      fstate_q   <= F_IDLE;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      req_ch_q   <= '0;
      req_gen_q  <= 1'b0;
      last_q     <= 3'd5;
`ifdef JT10_ADPCMA_EOS_EN
      eos_q      <= '0;
`endif
    end else begin
      start_q    <= start_d;
      end_q      <= end_d;
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      bvalid_q   <= bvalid_d;
      nib_q      <= nib_d;
      on_q       <= on_d;
      rst_pend_q <= rst_pend_d;
      gen_q      <= gen_d;
      underrun_q <= underrun_d;
      playing_q  <= playing_d;
      sc_q       <= sc_d;
      slot_q     <= slot_d;
      dec_data_q <= dec_data_d;
      dec_chon_q <= dec_chon_d;
      fstate_q   <= fstate_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      req_ch_q   <= req_ch_d;
      req_gen_q  <= req_gen_d;
      last_q     <= last_d;
`ifdef JT10_ADPCMA_EOS_EN
      eos_q      <= eos_d;
`endif
    end
  end

  assign rom.rom_cs   = rom_cs_q;
  assign rom.rom_addr = rom_addr_q;
  assign slot         = slot_q;
  assign dec_data     = dec_data_q;
  assign dec_chon     = dec_chon_q;
  assign playing      = playing_q;
  assign underrun     = underrun_q;
`ifdef JT10_ADPCMA_EOS_EN
  assign eos          = eos_q;
`endif

endmodule

// File: doc/jt10_adpcma_sched.md
# jt10_adpcma_sched

Sequencer for the six ADPCM-A channels that feed the time-multiplexed 6-stage ADPCM-A decoder. Holds per-channel start/end addresses and play state, prefetches sample bytes from sample ROM through a single shared request/acknowledge port, and presents one channel's nibble and `chon` per `cen` slot in round-robin order. It sits between the register file / sample ROM arbiter and the decoder datapath.

## Interface
- `ADDRW`, 24: sample ROM byte-address width.
- `rst_n` in 1: asynchronous reset, active-low.
- `clk` in 1: clock.
- `cen` in 1: slot clock enable; one decoder slot per `cen`.
- `wr_en` in 1: register write strobe, one `clk`.
- `wr_ch` in 3: target channel 0..5; values 6 and 7 are ignored.
- `wr_sel` in 1: 0 selects the start address, 1 selects the end address.
- `wr_data` in 16: address in 256-byte units.
- `keyon` in 6: per-channel start pulse, one `clk`.
- `keyoff` in 6: per-channel stop pulse, one `clk`.
- `rom_addr` out ADDRW: byte address.
- `rom_cs` out 1: request; held until `rom_ok`.
- `rom_data` in 8: read data, valid when `rom_ok`=1.
- `rom_ok` in 1: acknowledge, one `clk`.
- `slot` out 3: channel currently presented, 0..5.
- `dec_data` out 4: ADPCM nibble to the decoder.
- `dec_chon` out 1: channel-on to the decoder.
- `playing` out 6: per-channel active flag.
- `underrun` out 6: sticky flag, set when a nibble was needed and the buffer was empty; cleared on key-on.

## Operation
- **Per-channel state:** `start`, `end` (16b each), `addr` (ADDRW), `buf` (8b), `bvalid`, `nib` (0 = high nibble next), `on`, `rst_pend`, `gen` (1b tag).
- **Start/end mapping:** start byte address = `{start,8'h00}`; end byte address = `{end,8'hFF}`, inclusive.
- **Slot counter:** advances 0→5→0 on each `cen`.
  - Slot c with `rst_pend`: present `dec_chon`=0, `dec_data`=0 so the decoder resets its x/step. Then clear `rst_pend` and set `on`.
  - Slot c with `on`=0: present `dec_chon`=0, `dec_data`=0.
  - Slot c with `on`, `bvalid`: present `dec_chon`=1 and `buf[7:4]` if `nib`=0, else `buf[3:0]`. Toggle `nib`.
    - After a low-nibble output, clear `bvalid`.
    - If `addr`==end byte, clear `on`.
    - Otherwise `addr`+1, wrapping modulo 2^ADDRW.
  - Slot c with `on`, !`bvalid`: present `dec_chon`=1, `dec_data`=0, and set `underrun[c]`. `addr` and `nib` are unchanged.
- **Key-on:** load `addr`=start byte, `nib`=0, `bvalid`=0, set `rst_pend`, clear `on` and `underrun[c]`, toggle `gen`.
- **Key-off:** clear `on`, `rst_pend` and `bvalid`. If keyon and keyoff hit the same channel in the same cycle, keyoff wins.
- **Writes:** a write during playback updates only `start`/`end`. The new end takes effect at the next end compare.
- **Fetch engine** (runs every `clk`, independent of `cen`):
  - States:
    - IDLE: pick a channel.
    - REQ: `rom_cs`=1 and `rom_addr`=`addr[c]`, held stable until `rom_ok`.
    - IDLE again on `rom_ok`.
  - Eligible channel: (`on` or `rst_pend`) and !`bvalid`.
  - Arbitration: round-robin, searching from the channel after the last one served.
  - The `gen` value is latched at request time. On `rom_ok`, if `gen` is unchanged and the channel is still eligible, write `buf`, set `bvalid`. Otherwise discard the data.
  - One outstanding request at a time.
- **`playing[c]`** = `on` | `rst_pend`.

## Timing
- **Reset values:** `slot`=0, `dec_data`=0, `dec_chon`=0, `rom_cs`=0, `rom_addr`=0, `playing`=0, `underrun`=0; all channel state cleared, `start`=`end`=0.
- **Outputs:** `slot`/`dec_data`/`dec_chon` are registered and change only on `cen`. They describe slot n during the `cen` period after update.
- **Key-on to first audible nibble:** `dec_chon`=0 in the channel's first slot, and data in the next round at the earliest. This requires a ROM response within 5 `cen` periods; otherwise underrun.
- **Key-on/keyoff latency:** take effect in the `clk` after the pulse. A slot already presented is not retracted.
- **Steady-state bandwidth:** one byte per channel per 12 slots.
- **Async reset mid-request:** drops `rom_cs` immediately. ROM must tolerate an abandoned request.

## Configuration
- `JT10_ADPCMA_EOS_EN`: when defined, adds an `eos` output (6 bits) and an `eos_clr` input (6 bits).
  - `eos[c]` is set in the `clk` where the channel ends by reaching the end address, and cleared by `eos_clr[c]` or by key-on. Key-off does not set it.
  - When undefined, neither port exists and no logic is generated.

## Test plan
- Reset mid-REQ → `rom_cs`=0 asynchronously; all outputs at reset values; `slot` restarts at 0.
- ch2 start=0x0010, end=0x0010, keyon[2], `rom_ok` 3 clk after `rom_cs` → ch2 slot: `chon`=0 first, then 512 nibbles high/low from 0x1000..0x10FF; `playing[2]` falls after the low nibble of 0x10FF; `eos[2]`=1 if enabled.
- All six channels keyed on together, `rom_ok` latency 2 clk → round-robin fetch grants 0..5; no `underrun` bit set.
- `rom_ok` withheld for 20 `cen` → ch0 slots output `chon`=1, data=0, `underrun[0]`=1; `addr` not advanced.
- keyoff[3] while ch3's fetch is outstanding, then keyon[3] before `rom_ok` → stale byte discarded, new fetch from start; first ch3 slot `chon`=0.
- keyon[1] and keyoff[1] in the same clk → ch1 stays off; `playing[1]`=0.
